serial_frame_rx: RTL and testbench

//  Downstream consumer of the 4-bit universal shift register's serial output.

---
 rtl/serial_frame_rx.sv | 177 +++++++++++++++++
 tb/tb_serial_frame_rx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobed serial frame receiver (start '1', DW data bits, [even parity], stop '0').
// Latency: word and error pulses appear the cycle after the stop bit is sampled.
// Backpressure: one output register; a word completing while it is still held is dropped with ovr_err.
// Optional parity bit: define SERIAL_FRAME_RX_PARITY_EN to add the PARITY state (even parity).
module serial_frame_rx #(
  parameter int DW        = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sin,
  input  logic          sin_vld,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          busy,
  output logic          frm_err,
  output logic          par_err,
  output logic          ovr_err
);

  // Counter only has to reach DW-1, so clog2(DW) bits are enough for DW in 2..16.
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [DW-1:0] sr;
  logic [DW-1:0] sr_nxt;
  logic          push;
  logic          frm_nxt;
  logic          par_nxt;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic          par_bit;
  logic          par_bit_nxt;
`endif

  // Receive state register: FSM state, data bit counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  // Captured parity bit, held from the PARITY strobe until the stop bit is judged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else begin
      par_bit <= par_bit_nxt;
    end
  end
`endif

  // Next-state logic; nothing moves unless the bit strobe is high.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    push      = 1'b0;
    frm_nxt   = 1'b0;
    par_nxt   = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_bit_nxt = par_bit;
`endif
    if (sin_vld) begin
      case (state)
        IDLE: begin
          if (sin) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          // MSB-first shifts left so the first bit ends in dout[DW-1];
          // LSB-first shifts right so the first bit ends in dout[0].
          if (MSB_FIRST) begin
            sr_nxt = {sr[DW-2:0], sin};
          end else begin
            sr_nxt = {sin, sr[DW-1:1]};
          end
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            cnt_nxt = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
        PARITY: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          par_bit_nxt = sin;
`endif
          state_nxt = STOP;
        end
        STOP: begin
          // Framing error outranks parity error, so at most one flag fires per frame.
          state_nxt = IDLE;
          if (sin) begin
            frm_nxt = 1'b1;
          end
`ifdef SERIAL_FRAME_RX_PARITY_EN
          else if (^{sr, par_bit}) begin
            par_nxt = 1'b1;
          end
`endif
          else begin
            push = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output word register with valid/ready handshake and registered error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      frm_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      frm_err <= frm_nxt;
      ovr_err <= 1'b0;
      if (push) begin
        // A consumer accepting on this same edge frees the slot for the new word.
        if (dout_vld && !dout_rdy) begin
          ovr_err <= 1'b1;
        end else begin
          dout     <= sr;
          dout_vld <= 1'b1;
        end
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  // Registered parity error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= par_nxt;
    end
  end
`else
  assign par_err = 1'b0;
  logic unused_par;
  assign unused_par = par_nxt;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: vector table, directed corner sequences and a randomized
// frame stream checked every cycle against a bit-collecting frame model.
// Two instances share the serial inputs: one MSB-first, one LSB-first (DW=4).
module tb_serial_frame_rx;

  localparam int DW = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk;
  logic          rst;
  logic          sin;
  logic          sin_vld;
  logic          rdy;
  logic [DW-1:0] dout_a, dout_b;
  logic          dout_vld_a, dout_vld_b;
  logic          busy_a, busy_b;
  logic          frm_err_a, frm_err_b;
  logic          par_err_a, par_err_b;
  logic          ovr_err_a, ovr_err_b;

  int n_vec;
  int n_bad;

  bit gap_en;
  bit rdy_rand;
  bit toggle;

  // Behavioural model state, one slot per instance.
  bit       m_in   [2];
  int       m_n    [2];
  bit       m_bits [2][32];
  logic [3:0] m_dout [2];
  bit       m_vld  [2];
  bit       m_frm  [2];
  bit       m_par  [2];
  bit       m_ovr  [2];

  serial_frame_rx #(.DW(DW), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld),
    .dout(dout_a), .dout_vld(dout_vld_a), .dout_rdy(rdy), .busy(busy_a),
    .frm_err(frm_err_a), .par_err(par_err_a), .ovr_err(ovr_err_a)
  );

  serial_frame_rx #(.DW(DW), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld),
    .dout(dout_b), .dout_vld(dout_vld_b), .dout_rdy(rdy), .busy(busy_b),
    .frm_err(frm_err_b), .par_err(par_err_b), .ovr_err(ovr_err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: after a start '1', collect DW+PB+1 strobed bits, then judge the frame.
  task automatic model_step(input int k, input bit msb);
    bit         push;
    bit         p;
    logic [3:0] w;
    push = 0;
    w = '0;
    m_frm[k] = 0;
    m_par[k] = 0;
    m_ovr[k] = 0;
    if (rst) begin
      m_in[k] = 0; m_n[k] = 0; m_dout[k] = '0; m_vld[k] = 0;
      return;
    end
    if (sin_vld) begin
      if (!m_in[k]) begin
        if (sin) begin
          m_in[k] = 1;
          m_n[k] = 0;
        end
      end else begin
        m_bits[k][m_n[k]] = sin;
        m_n[k]++;
        if (m_n[k] == DW + PB + 1) begin
          m_in[k] = 0;
          p = 0;
          for (int i = 0; i < DW + PB; i++) p ^= m_bits[k][i];
          for (int i = 0; i < DW; i++) begin
            if (msb) w[DW-1-i] = m_bits[k][i];
            else     w[i] = m_bits[k][i];
          end
          if (m_bits[k][DW+PB]) m_frm[k] = 1;
          else if (PB == 1 && p) m_par[k] = 1;
          else push = 1;
        end
      end
    end
    if (push) begin
      if (m_vld[k] && !rdy) m_ovr[k] = 1;
      else begin
        m_dout[k] = w;
        m_vld[k] = 1;
      end
    end else if (m_vld[k] && rdy) begin
      m_vld[k] = 0;
    end
  endtask

  task automatic chk_model(input int k, input logic [3:0] d, input logic v, input logic b,
                           input logic f, input logic p, input logic o);
    string s;
    s = (k == 0) ? "a" : "b";
    chk({s, ".dout_vld"}, v, m_vld[k]);
    if (m_vld[k]) chk({s, ".dout"}, d, m_dout[k]);
    chk({s, ".busy"}, b, m_in[k]);
    chk({s, ".frm_err"}, f, m_frm[k]);
    chk({s, ".par_err"}, p, m_par[k]);
    chk({s, ".ovr_err"}, o, m_ovr[k]);
  endtask

  // One clock: advance the model with the applied inputs, then sample #1 after the edge.
  task automatic tick();
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    @(posedge clk);
    #1;
    chk_model(0, dout_a, dout_vld_a, busy_a, frm_err_a, par_err_a, ovr_err_a);
    chk_model(1, dout_b, dout_vld_b, busy_b, frm_err_b, par_err_b, ovr_err_b);
  endtask

  task automatic send_bit(input bit b);
    if (gap_en) begin
      for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
        sin_vld = 0;
        sin = 1'($urandom);
        if (rdy_rand) rdy = 1'($urandom);
        tick();
      end
    end
    sin = b;
    sin_vld = 1;
    if (rdy_rand) rdy = 1'($urandom_range(0, 1));
    tick();
    if (toggle) begin
      sin_vld = 0;
      sin = ~b;
      tick();
    end
    sin_vld = 0;
  endtask

  // Bits go out in MSB-first order of 'data'; the LSB-first instance sees them reversed.
  task automatic send_frame(input logic [3:0] data, input bit bad_stop, input bit bad_par);
    send_bit(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(data[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_bit((^data) ^ bad_par);
`else
    if (bad_par) begin
      // no parity bit in this build
    end
`endif
    send_bit(bad_stop);
  endtask

  typedef struct {
    bit         sin;
    bit         vld;
    bit         rdy;
    bit         e_vld;
    logic [3:0] e_dout;
    bit         e_busy;
    bit         e_frm;
    bit         e_ovr;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit v, input bit r, input bit ev,
                              input logic [3:0] ed, input bit eb, input bit ef, input bit eo);
    vec_t x;
    x.sin = s; x.vld = v; x.rdy = r; x.e_vld = ev;
    x.e_dout = ed; x.e_busy = eb; x.e_frm = ef; x.e_ovr = eo;
    return x;
  endfunction

  initial begin
    vec_t tbl[$];
    n_vec = 0;
    n_bad = 0;
    gap_en = 0;
    rdy_rand = 0;
    toggle = 0;
    rst = 1;
    sin = 0;
    sin_vld = 0;
    rdy = 0;
    #1;
    chk("rst.dout_vld", dout_vld_a, 0);
    chk("rst.dout", dout_a, 0);
    chk("rst.busy", busy_a, 0);
    chk("rst.errs", {frm_err_a, par_err_a, ovr_err_a, frm_err_b, par_err_b, ovr_err_b}, 0);
    tick();
    tick();
    rst = 0;
    tick();

`ifndef SERIAL_FRAME_RX_PARITY_EN
    // good frame 1010, hold, accept / bad stop / overrun then accept-on-push
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4'hA,0,0,0));
    tbl.push_back(mk(0,0,0, 1,4'hA,0,0,0));
    tbl.push_back(mk(0,0,1, 0,4'h0,0,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,4'h0,0,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(1,1,0, 0,4'h0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4'h3,0,0,0));
    tbl.push_back(mk(1,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(1,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(1,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4'h3,0,0,1));
    tbl.push_back(mk(0,0,0, 1,4'h3,0,0,0));
    tbl.push_back(mk(1,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(1,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(1,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4'h3,1,0,0));
    tbl.push_back(mk(0,1,1, 1,4'hC,0,0,0));
    tbl.push_back(mk(0,0,1, 0,4'h0,0,0,0));
    for (int i = 0; i < tbl.size(); i++) begin
      sin = tbl[i].sin;
      sin_vld = tbl[i].vld;
      rdy = tbl[i].rdy;
      tick();
      chk($sformatf("tbl[%0d].dout_vld", i), dout_vld_a, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("tbl[%0d].dout", i), dout_a, tbl[i].e_dout);
      chk($sformatf("tbl[%0d].busy", i), busy_a, tbl[i].e_busy);
      chk($sformatf("tbl[%0d].frm_err", i), frm_err_a, tbl[i].e_frm);
      chk($sformatf("tbl[%0d].ovr_err", i), ovr_err_a, tbl[i].e_ovr);
      chk($sformatf("tbl[%0d].par_err", i), par_err_a, 0);
    end
`else
    // parity: good even-parity frame, then the same data with the parity bit flipped
    rdy = 0;
    send_frame(4'b1010, 1'b0, 1'b0);
    chk("par.good.dout_vld", dout_vld_a, 1);
    chk("par.good.dout", dout_a, 4'b1010);
    chk("par.good.par_err", par_err_a, 0);
    rdy = 1;
    tick();
    chk("par.accept.dout_vld", dout_vld_a, 0);
    rdy = 0;
    send_frame(4'b1010, 1'b0, 1'b1);
    chk("par.bad.par_err", par_err_a, 1);
    chk("par.bad.frm_err", frm_err_a, 0);
    chk("par.bad.dout_vld", dout_vld_a, 0);
    tick();
    chk("par.bad.pulse_end", par_err_a, 0);
`endif

    // reset after two data bits drops the partial frame and the held word
    rdy = 0;
    send_frame(4'b0101, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("midrst.busy_before", busy_a, 1);
    rst = 1;
    #1;
    chk("midrst.busy", busy_a, 0);
    chk("midrst.dout_vld", dout_vld_a, 0);
    chk("midrst.dout", dout_a, 0);
    chk("midrst.errs", {frm_err_a, par_err_a, ovr_err_a}, 0);
    tick();
    rst = 0;
    tick();
    send_frame(4'b0110, 1'b0, 1'b0);
    chk("postrst.dout_vld", dout_vld_a, 1);
    chk("postrst.dout", dout_a, 4'b0110);
    chk("postrst.busy", busy_a, 0);

    // LSB-first with a gap after every strobe
    rdy = 1;
    tick();
    rdy = 0;
    toggle = 1;
    send_frame(4'b1000, 1'b0, 1'b0);
    toggle = 0;
    chk("lsb.dout_vld", dout_vld_b, 1);
    chk("lsb.dout", dout_b, 4'b0001);
    chk("lsb.msb_dout", dout_a, 4'b1000);

    // randomized frame stream with gaps, bad stop/parity bits and random backpressure
    gap_en = 1;
    rdy_rand = 1;
    for (int f = 0; f < 300; f++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) send_bit(1'b0);
      send_frame(4'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
    gap_en = 0;
    rdy_rand = 0;
    rdy = 1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
